// File: rtl/bn_stream_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : bn_stream_scheduler_if
// Brief    : Activation stream, batch-norm datapath and result stream bundle.
// Revision : 1.0
// ============================================================================
interface bn_stream_scheduler_if #(
    parameter int WIDTH = 16,
    parameter int CW    = 6
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    logic             bn_en;
    logic [WIDTH-1:0] bn_x;
    logic [CW-1:0]    bn_channel;
    logic             bn_valid;
    logic [WIDTH-1:0] bn_y;
    logic [CW-1:0]    bn_channel_ret;
    logic             bn_valid_ret;

    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_channel;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        input  in_data, in_valid,
        output in_ready,
        output bn_en, bn_x, bn_channel, bn_valid,
        input  bn_y, bn_channel_ret, bn_valid_ret,
        output out_data, out_channel, out_valid, out_last,
        input  out_ready
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready,
        input  bn_en, bn_x, bn_channel, bn_valid,
        output bn_y, bn_channel_ret, bn_valid_ret,
        input  out_data, out_channel, out_valid, out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/bn_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bn_stream_scheduler
// Brief    : Credit-throttled issue of one feature map through a fixed-latency
//            batch-norm datapath, with a FWFT result FIFO and frame framing.
// Revision : 1.0
// ============================================================================
module bn_stream_scheduler #(
    parameter int WIDTH         = 16,
    parameter int CHANNELS      = 48,
    parameter int PIXELS        = 196,
    parameter int BN_LATENCY    = 6,
    parameter int FIFO_DEPTH    = 8,
    parameter int WARMUP_CYCLES = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    bn_stream_scheduler_if.master bus
);

    localparam int c_cw  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_xw  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int c_pw  = $clog2(FIFO_DEPTH);
    // Inflight is bounded both by the credit window and by the pipe depth.
    localparam int c_ifw = $clog2(FIFO_DEPTH + BN_LATENCY + 2);
    localparam int c_sw  = c_ifw + 1;
    localparam int c_ww  = $clog2(WARMUP_CYCLES + 1);

    localparam logic [c_cw-1:0] c_ch_last   = c_cw'(CHANNELS - 1);
    localparam logic [c_xw-1:0] c_pix_last  = c_xw'(PIXELS - 1);
    localparam logic [c_ww-1:0] c_warm_last = c_ww'(WARMUP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WARMUP = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [c_ww-1:0]   r_warm_cnt;
    logic [c_cw-1:0]   r_ch_cnt;
    logic [c_xw-1:0]   r_pix_cnt;
    logic [c_cw-1:0]   r_ret_ch;
    logic [c_xw-1:0]   r_ret_pix;
    logic [c_ifw-1:0]  r_inflight;
    logic [WIDTH-1:0]  r_bn_x;
    logic [c_cw-1:0]   r_bn_ch;
    logic              r_bn_valid;
    logic              r_err;

    logic [WIDTH-1:0]  r_mem_data [FIFO_DEPTH];
    logic [c_cw-1:0]   r_mem_ch   [FIFO_DEPTH];
    logic              r_mem_last [FIFO_DEPTH];
    logic [c_pw-1:0]   r_wr_ptr;
    logic [c_pw-1:0]   r_rd_ptr;
    logic [c_pw:0]     r_count;

    logic              w_busy;
    logic              w_done;
    logic              w_bn_en;
    logic              w_start_frame;
    logic              w_in_ready;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_ret_acc;
    logic              w_ret_last;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_overflow;
    logic [c_sw-1:0]   w_occupancy;

    // The word registered in bn_x this cycle holds a credit before inflight counts it.
    assign w_occupancy  = c_sw'(r_inflight) + c_sw'(r_bn_valid) + c_sw'(r_count);
    assign w_in_ready   = (r_state == S_RUN) && (w_occupancy < c_sw'(FIFO_DEPTH));
    assign w_issue      = bus.in_valid && w_in_ready;
    assign w_last_issue = (r_ch_cnt == c_ch_last) && (r_pix_cnt == c_pix_last);

    assign w_ret_acc    = bus.bn_valid_ret && (r_state != S_IDLE);
    assign w_ret_last   = (r_ret_ch == c_ch_last) && (r_ret_pix == c_pix_last);

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == (c_pw + 1)'(FIFO_DEPTH));
    assign w_pop        = !w_empty && bus.out_ready;
    assign w_push       = w_ret_acc && (!w_full || w_pop);
    assign w_overflow   = w_ret_acc && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_busy        = 1'b0;
        w_done        = 1'b0;
        w_bn_en       = 1'b0;
        w_start_frame = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_frame = 1'b1;
                    w_state_nxt   = S_WARMUP;
                end
            end
            S_WARMUP: begin
                w_busy  = 1'b1;
                w_bn_en = 1'b1;
                if (r_warm_cnt == c_warm_last) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy  = 1'b1;
                w_bn_en = 1'b1;
                if (w_issue && w_last_issue) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy  = 1'b1;
                w_bn_en = 1'b1;
                if ((r_inflight == '0) && !r_bn_valid && w_empty) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm_cnt <= '0;
            r_ch_cnt   <= '0;
            r_pix_cnt  <= '0;
            r_ret_ch   <= '0;
            r_ret_pix  <= '0;
            r_inflight <= '0;
            r_bn_x     <= '0;
            r_bn_ch    <= '0;
            r_bn_valid <= 1'b0;
            r_err      <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_bn_valid <= w_issue;

            if (w_start_frame) begin
                r_warm_cnt <= '0;
                r_ch_cnt   <= '0;
                r_pix_cnt  <= '0;
                r_ret_ch   <= '0;
                r_ret_pix  <= '0;
                r_err      <= 1'b0;
            end else if (r_state == S_WARMUP) begin
                r_warm_cnt <= r_warm_cnt + c_ww'(1);
            end

            if (w_issue) begin
                r_bn_x  <= bus.in_data;
                r_bn_ch <= r_ch_cnt;
                if (r_ch_cnt == c_ch_last) begin
                    r_ch_cnt  <= '0;
                    r_pix_cnt <= (r_pix_cnt == c_pix_last) ? '0 : r_pix_cnt + c_xw'(1);
                end else begin
                    r_ch_cnt <= r_ch_cnt + c_cw'(1);
                end
            end

            if (r_bn_valid && !w_ret_acc) begin
                r_inflight <= r_inflight + c_ifw'(1);
            end else if (!r_bn_valid && w_ret_acc && (r_inflight != '0)) begin
                r_inflight <= r_inflight - c_ifw'(1);
            end

            // A wrong channel or a full FIFO both flag err; the data is kept when it fits.
            if (w_ret_acc) begin
                if ((bus.bn_channel_ret != r_ret_ch) || w_overflow) begin
                    r_err <= 1'b1;
                end
                if (r_ret_ch == c_ch_last) begin
                    r_ret_ch  <= '0;
                    r_ret_pix <= (r_ret_pix == c_pix_last) ? '0 : r_ret_pix + c_xw'(1);
                end else begin
                    r_ret_ch <= r_ret_ch + c_cw'(1);
                end
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_pw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_pw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_pw + 1)'(1);
                2'b01:   r_count <= r_count - (c_pw + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= bus.bn_y;
            r_mem_ch[r_wr_ptr]   <= bus.bn_channel_ret;
            r_mem_last[r_wr_ptr] <= w_ret_last;
        end
    end

    assign busy            = w_busy;
    assign done            = w_done;
    assign err             = r_err;

    assign bus.in_ready    = w_in_ready;
    assign bus.bn_en       = w_bn_en;
    assign bus.bn_x        = r_bn_x;
    assign bus.bn_channel  = r_bn_ch;
    assign bus.bn_valid    = r_bn_valid;

    // Head fields read as zero while empty so stale storage never leaks out.
    assign bus.out_valid   = !w_empty;
    assign bus.out_data    = w_empty ? '0 : r_mem_data[r_rd_ptr];
    assign bus.out_channel = w_empty ? '0 : r_mem_ch[r_rd_ptr];
    assign bus.out_last    = w_empty ? 1'b0 : r_mem_last[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_bn_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bn_stream_scheduler
// Brief    : Scoreboard bench with an identity datapath model of fixed latency.
// Revision : 1.0
// ============================================================================
module tb_bn_stream_scheduler;

    localparam int W     = 16;
    localparam int CH    = 4;
    localparam int PIX   = 2;
    localparam int TOTAL = CH * PIX;
    localparam int LAT   = 6;
    localparam int FD    = 4;
    localparam int WARM  = 4;
    localparam int CW    = 2;
    localparam logic [W-1:0] MAGIC = 16'hBAD0;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [CW-1:0] ch;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic err;

    always #5 clk = ~clk;

    bn_stream_scheduler_if #(.WIDTH(W), .CW(CW)) bus ();

    bn_stream_scheduler #(
        .WIDTH(W), .CHANNELS(CH), .PIXELS(PIX), .BN_LATENCY(LAT),
        .FIFO_DEPTH(FD), .WARMUP_CYCLES(WARM)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bus   (bus.master)
    );

    // Identity datapath; MAGIC data comes back tagged with the wrong channel.
    bit [W+CW:0]   pipe [LAT];
    logic [CW-1:0] model_ch;
    assign model_ch = (bus.bn_x == MAGIC) ? CW'(bus.bn_channel + 1'b1) : bus.bn_channel;

    always @(posedge clk) begin
        pipe[0] <= {bus.bn_valid, model_ch, bus.bn_x};
        for (int i = 1; i < LAT; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign bus.bn_valid_ret   = pipe[LAT-1][W+CW];
    assign bus.bn_channel_ret = pipe[LAT-1][W+CW-1:W];
    assign bus.bn_y           = pipe[LAT-1][W-1:0];

    int n_chk = 0;
    int n_err = 0;
    int in_cnt = 0;
    int out_cnt = 0;
    int done_cnt = 0;
    int stale_ret = 0;
    int out_mode = 1;
    bit err_pending = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            case (out_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: samples what the DUT will see at the coming rising edge.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            #1;
            if (!busy && bus.bn_valid_ret) begin
                stale_ret++;
            end
            if (rst) begin
                sb.delete();
                in_cnt = 0;
                err_pending = 0;
            end else begin
                if (err_pending) begin
                    check("err_after_bad_ret", 32'(err), 32'd1);
                    err_pending = 0;
                end
                if (busy && bus.bn_valid_ret && (bus.bn_y == MAGIC)) begin
                    check("err_before_bad_ret", 32'(err), 32'd0);
                    err_pending = 1;
                end
                if (done) begin
                    done_cnt++;
                end
                if (start && !busy && !done) begin
                    in_cnt = 0;
                end
                if (bus.in_valid && bus.in_ready) begin
                    e.d    = bus.in_data;
                    e.ch   = (bus.in_data == MAGIC) ? CW'((in_cnt + 1) % CH) : CW'(in_cnt % CH);
                    e.last = (in_cnt == TOTAL - 1);
                    sb.push_back(e);
                    in_cnt++;
                end
                if (bus.out_valid && bus.out_ready) begin
                    out_cnt++;
                    got = {bus.out_data, bus.out_channel, bus.out_last};
                    if (sb.size() == 0) begin
                        check("unexpected_out", 32'(got), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("out_word", 32'(got), 32'(e));
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [W-1:0] d);
        int t;
        t = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        #1;
        while (bus.in_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 2000) begin
            n_chk++;
            n_err++;
            $display("FAIL send_timeout: in_ready=%0b, expected 1", bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (done_cnt == d0) begin
            n_chk++;
            n_err++;
            $display("FAIL done_timeout: done count=%0d, expected %0d", done_cnt, d0 + 1);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("start_busy", 32'(busy), 32'd1);
        check("start_err_clr", 32'(err), 32'd0);
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [W-1:0] base, input bit rand_gap,
                             input int magic_idx, input int pulse_idx, input bit exp_err);
        int d0;
        int o0;
        int gap;
        d0 = done_cnt;
        o0 = out_cnt;
        pulse_start();
        for (int i = 0; i < TOTAL; i++) begin
            if (rand_gap) begin
                gap = int'($urandom_range(0, 2));
                if (gap > 0) begin
                    bus.in_valid = 1'b0;
                    repeat (gap) @(negedge clk);
                end
            end
            if (i == pulse_idx) start = 1'b1;
            send_word((i == magic_idx) ? MAGIC : base + W'(i));
            start = 1'b0;
        end
        bus.in_valid = 1'b0;
        if (pulse_idx >= 0) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(d0);
        check("frame_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("frame_outputs", 32'(out_cnt - o0), 32'(TOTAL));
        check("frame_issues", 32'(in_cnt), 32'(TOTAL));
        check("frame_err", 32'(err), 32'(exp_err));
    endtask

    initial begin
        int d0;
        int o0;
        int s0;
        int ov;
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ctrl", {busy, done, err, bus.in_ready, bus.bn_en, bus.bn_valid, bus.out_valid}, 32'd0);
        check("reset_data", {bus.bn_x, bus.out_data}, 32'd0);

        // Continuous input, continuous drain
        out_mode = 1;
        run_frame(16'h0100, 1'b0, -1, -1, 1'b0);

        // Output stalled: only FIFO_DEPTH words may be issued
        d0 = done_cnt;
        o0 = out_cnt;
        out_mode = 0;
        pulse_start();
        fork
            begin
                for (int i = 0; i < TOTAL; i++) send_word(16'h2000 + W'(i));
                bus.in_valid = 1'b0;
            end
            begin
                repeat (40) @(negedge clk);
                #2;
                check("stall_issues", 32'(in_cnt), 32'(FD));
                check("stall_in_ready", 32'(bus.in_ready), 32'd0);
                check("stall_out_valid", 32'(bus.out_valid), 32'd1);
                check("stall_no_output", 32'(out_cnt - o0), 32'd0);
                out_mode = 1;
            end
        join
        wait_done(d0);
        check("stall_outputs", 32'(out_cnt - o0), 32'(TOTAL));

        // Random gaps and backpressure, three frames back to back
        out_mode = 2;
        for (int f = 0; f < 3; f++) begin
            run_frame(16'h3000 + W'(f * 16'h100), 1'b1, -1, -1, 1'b0);
        end
        out_mode = 1;

        // Wrong channel returned for word 2
        run_frame(16'h4000, 1'b0, 2, -1, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("err_sticky", 32'(err), 32'd1);
        @(negedge clk);

        // Start pulses during RUN and DRAIN are ignored; err clears at start
        run_frame(16'h6000, 1'b0, -1, 3, 1'b0);
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        #1;
        check("no_restart_busy", 32'(busy), 32'd0);
        check("no_extra_done", 32'(done_cnt - d0), 32'd0);
        @(negedge clk);

        // Reset with three words in flight
        pulse_start();
        for (int i = 0; i < 3; i++) send_word(16'h5000 + W'(i));
        bus.in_valid = 1'b0;
        rst = 1'b1;
        s0 = stale_ret;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ctrl", {busy, done, err, bus.in_ready, bus.bn_en, bus.bn_valid, bus.out_valid, bus.out_last}, 32'd0);
        check("rst_bn_data", {bus.bn_x, 14'd0, bus.bn_channel}, 32'd0);
        check("rst_out_data", {bus.out_data, 14'd0, bus.out_channel}, 32'd0);
        ov = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) ov++;
        end
        check("rst_stale_out", 32'(ov), 32'd0);
        check("rst_stale_returns", 32'(stale_ret - s0), 32'd3);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
